ysyx_040750_divider: RTL
========================

YSYX_040750_DIVIDER -- requirements
Module: ysyx_040750_divider

Interface
REQ-001 SHALL have a single clock and reset: synchronous, active-high; the port lines follow.
REQ-002 SHALL provide: clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL provide: rst  input  1  synchronous active-high reset.
REQ-004 SHALL provide: flush  input  1  abort current operation (pipeline flush).
REQ-005 SHALL provide: div_valid  input  1  request valid.
REQ-006 SHALL provide: div_ready  output  1  high only in IDLE; accept = div_valid & div_ready & ~flush.
REQ-007 SHALL provide: div_signed  input  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
REQ-008 SHALL provide: divw  input  1  1 = RV64 word op on low 32 bits.
REQ-009 SHALL provide: dividend  input  64  numerator, sampled at accept.
REQ-010 SHALL provide: divisor  input  64  denominator, sampled at accept.
REQ-011 SHALL provide: out_valid  output  1  result valid, one cycle per operation.
REQ-012 SHALL provide: quotient  output  64  registered quotient.
REQ-013 SHALL provide: remainder  output  64  registered remainder.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE.
- IDLE -> CALC on accept with nonzero divisor.
- IDLE -> DONE on accept with zero divisor.
- CALC -> DONE after N iterations.
- DONE -> IDLE unconditionally.
REQ-015 SHALL use N = 64 iterations when divw=0 and N = 32 when divw=1, with an iteration counter loaded at accept.
REQ-016 SHALL perform one radix-2 shift-subtract step per CALC cycle on operand magnitudes.
- Magnitude = two's-complement absolute value when div_signed=1 and the operand MSB is set.
- The result sign is applied at the CALC->DONE edge.
REQ-017 SHALL, for divw=1, sign-extend (div_signed=1) or zero-extend (div_signed=0) bits [31:0] of both operands before use.
- It SHALL sign-extend the 32-bit quotient and remainder to 64 bits in both signed and unsigned modes.
REQ-018 SHALL set the quotient sign as dividend sign XOR divisor sign, and the remainder sign equal to the dividend sign (signed mode only).
REQ-019 SHALL, on a zero divisor, return quotient = all ones (64-bit, or sign-extended 32-bit all ones in word mode) and remainder = dividend (extended per REQ-017), regardless of div_signed.
REQ-020 SHALL, on signed overflow (most-negative / -1), return quotient = dividend and remainder = 0 without special-case logic beyond REQ-016/018.
REQ-021 SHALL raise out_valid N+1 rising edges after the accepting edge for a nonzero divisor, and 1 edge after it for a zero divisor.
REQ-022 SHALL define out_valid = (state==DONE) & ~flush, so it is high for exactly one cycle.
REQ-023 SHALL hold quotient and remainder stable from DONE until the next DONE; they change only at the edge entering DONE.
REQ-024 SHALL give flush priority over all events.
- flush in any state forces IDLE at the next edge.
- No accept occurs while flush=1, even with div_valid=1.
- An aborted operation never produces out_valid.
REQ-025 SHALL ignore div_valid and all operand inputs while not in IDLE.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, set state = IDLE, counter = 0, quotient = 0, remainder = 0, and all internal operand registers = 0.
REQ-027 SHALL drive out_valid = 0 and div_ready = 1 in the cycle after reset.
REQ-028 SHALL treat reset asserted mid-CALC as an abort: no out_valid for that operation.
REQ-029 SHALL give rst priority over flush and accept.

Verification
REQ-030 SHALL cover unsigned 64-bit division.
- Stimulus: dividend=100, divisor=7, div_signed=0, divw=0.
- Response: out_valid exactly 65 edges after accept; quotient=14, remainder=2.
REQ-031 SHALL cover signed division with a negative dividend.
- Stimulus: dividend=-7 (0xFFFF_FFFF_FFFF_FFF9), divisor=2, div_signed=1.
- Response: quotient=-3, remainder=-1.
REQ-032 SHALL cover signed overflow.
- Stimulus: dividend=0x8000_0000_0000_0000, divisor=-1, div_signed=1.
- Response: quotient=0x8000_0000_0000_0000, remainder=0.
REQ-033 SHALL cover zero divisor.
- Stimulus: dividend=0x1234, divisor=0, div_signed=1.
- Response: out_valid 1 edge after accept; quotient=0xFFFF_FFFF_FFFF_FFFF, remainder=0x1234.
REQ-034 SHALL cover unsigned word mode.
- Stimulus: divw=1, div_signed=0, dividend=0xDEAD_0000_FFFF_FFFE, divisor=0x0000_0000_0000_0002.
- Response: out_valid 33 edges after accept; quotient=0x0000_0000_7FFF_FFFF, remainder=0.
REQ-035 SHALL cover flush mid-operation.
- Stimulus: flush at CALC iteration 10.
- Response: div_ready=1 the next cycle, no out_valid.
- A following request, 9/3 unsigned, returns quotient=3, remainder=0.

Source files
------------

// File: rtl/ysyx_040750_divider.sv
// ysyx_040750_divider: iterative radix-2 divider for RV64 DIV/DIVU/REM/REMU and
// their word variants. Each CALC cycle retires one quotient bit from operand
// magnitudes. The result sign and the word-mode extension are applied when the
// last step is taken.
module ysyx_040750_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        div_valid,
  output logic        div_ready,
  input  logic        div_signed,
  input  logic        divw,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic        out_valid,
  output logic [63:0] quotient,
  output logic [63:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Sign-extend a 32-bit value to 64 bits.
  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Two's-complement negate when en is set, pass-through otherwise.
  function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic en);
    return en ? (~v + 64'd1) : v;
  endfunction

  state_t      state_r;
  logic [6:0]  cnt_r;
  logic [63:0] quo_r;    // dividend magnitude shifting out, quotient bits shifting in
  logic [63:0] rem_r;    // partial remainder
  logic [63:0] dsr_r;    // divisor magnitude
  logic        neg_q_r;
  logic        neg_r_r;
  logic        divw_r;

  logic        accept_s;
  logic [63:0] dvd_ext_s;
  logic [63:0] dsr_ext_s;
  logic        dvd_neg_s;
  logic        dsr_neg_s;
  logic [63:0] dvd_mag_s;
  logic [63:0] dsr_mag_s;
  logic        dsr_zero_s;
  logic [64:0] trial_s;
  logic [64:0] diff_s;
  logic        ge_s;
  logic [63:0] quo_nxt_s;
  logic [63:0] rem_nxt_s;
  logic [63:0] q_sgn_s;
  logic [63:0] r_sgn_s;
  logic [63:0] q_fin_s;
  logic [63:0] r_fin_s;

  assign div_ready = (state_r == IDLE);
  assign out_valid = (state_r == DONE) & ~flush;
  assign accept_s  = div_valid & div_ready & ~flush;

  // Operand preparation: word-mode extension, sign detection and magnitudes.
  assign dvd_ext_s  = divw ? (div_signed ? sext32(dividend[31:0]) : {32'd0, dividend[31:0]}) : dividend;
  assign dsr_ext_s  = divw ? (div_signed ? sext32(divisor[31:0])  : {32'd0, divisor[31:0]})  : divisor;
  assign dvd_neg_s  = div_signed & dvd_ext_s[63];
  assign dsr_neg_s  = div_signed & dsr_ext_s[63];
  assign dvd_mag_s  = cond_neg(dvd_ext_s, dvd_neg_s);
  assign dsr_mag_s  = cond_neg(dsr_ext_s, dsr_neg_s);
  assign dsr_zero_s = (dsr_ext_s == 64'd0);

  // One restoring shift-subtract step. The borrow out of the 65-bit difference
  // decides the quotient bit, because the trial value is always below twice
  // the divisor.
  assign trial_s   = {rem_r, quo_r[63]};
  assign diff_s    = trial_s - {1'b0, dsr_r};
  assign ge_s      = ~diff_s[64];
  assign rem_nxt_s = ge_s ? diff_s[63:0] : trial_s[63:0];
  assign quo_nxt_s = {quo_r[62:0], ge_s};

  // Final results. The signs come from the operands, and word results are
  // sign-extended from bit 31 in both signed and unsigned modes.
  assign q_sgn_s = cond_neg(quo_nxt_s, neg_q_r);
  assign r_sgn_s = cond_neg(rem_nxt_s, neg_r_r);
  assign q_fin_s = divw_r ? sext32(q_sgn_s[31:0]) : q_sgn_s;
  assign r_fin_s = divw_r ? sext32(r_sgn_s[31:0]) : r_sgn_s;

  // Control FSM and datapath registers. Reset has priority over flush, and
  // flush has priority over everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= 7'd0;
      quo_r     <= 64'd0;
      rem_r     <= 64'd0;
      dsr_r     <= 64'd0;
      neg_q_r   <= 1'b0;
      neg_r_r   <= 1'b0;
      divw_r    <= 1'b0;
      quotient  <= 64'd0;
      remainder <= 64'd0;
    end else if (flush) begin
      state_r <= IDLE;
      cnt_r   <= 7'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            divw_r <= divw;
            if (dsr_zero_s) begin
              state_r   <= DONE;
              quotient  <= 64'hFFFF_FFFF_FFFF_FFFF;
              remainder <= divw ? sext32(dvd_ext_s[31:0]) : dvd_ext_s;
            end else begin
              state_r <= CALC;
              cnt_r   <= divw ? 7'd32 : 7'd64;
              quo_r   <= divw ? {dvd_mag_s[31:0], 32'd0} : dvd_mag_s;
              rem_r   <= 64'd0;
              dsr_r   <= dsr_mag_s;
              neg_q_r <= dvd_neg_s ^ dsr_neg_s;
              neg_r_r <= dvd_neg_s;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          quo_r <= quo_nxt_s;
          rem_r <= rem_nxt_s;
          cnt_r <= cnt_r - 7'd1;
          if (cnt_r == 7'd1) begin
            state_r   <= DONE;
            quotient  <= q_fin_s;
            remainder <= r_fin_s;
          end else begin
            state_r <= CALC;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
